reg_checker: RTL and testbench
==============================

# reg_checker

Self-checking reader for the register test path. It samples the stimulus written into the register under test and the register's output. It compares each output against the stimulus delayed by a fixed latency, and reports pass/fail, match counts and the first mismatch. It sits beside the register wrapper in mixed VHDL/SystemVerilog benches and in on-chip self-test, and observes the same data_in/data_out pair the wrapper connects.

## Interface
- DWIDTH, 32, data width of the observed register
- LATENCY, 1, stimulus-to-output delay of the register under test in clock cycles (legal 1..8)
- CNT_W, 16, width of the check and error counters

- clk_i  in  1  clock, rising-edge
- rst_i  in  1  reset, asynchronous, active-low
- start_i  in  1  begin a checking run; honoured only in IDLE
- stop_i  in  1  end stimulus capture; honoured only in RUN
- data_in_i  in  DWIDTH  stimulus applied to the register under test
- data_out_i  in  DWIDTH  register under test output
- busy_o  out  1  high in RUN and DRAIN
- done_o  out  1  one-cycle pulse when a run completes
- pass_o  out  1  run result: err_cnt_o==0 and chk_cnt_o!=0; valid from done_o until next start
- err_o  out  1  sticky; set on any mismatch in the current run
- chk_cnt_o  out  CNT_W  comparisons performed, saturating
- err_cnt_o  out  CNT_W  mismatches seen, saturating
- first_exp_o  out  DWIDTH  expected value of the first mismatch
- first_act_o  out  DWIDTH  actual value of the first mismatch

## Operation
- Reset, asynchronous, applied at any time:
  - state IDLE; delay line valid bits cleared.
  - All outputs 0: busy, done, pass, err, both counters, first_exp, first_act.
- Delay line has LATENCY stages, each holding a data word and a valid bit.
  - Stage 0 captures data_in_i with valid=capture on every edge.
  - capture = (IDLE and start_i) or (RUN and not stop_i).
  - All other stages shift unconditionally.
- Compare on every edge where the last stage is valid:
  - chk_cnt++.
  - If data_out_i != last-stage data: err_cnt++ and err_o=1.
  - If it is the first mismatch of the run, latch first_exp/first_act.
  - Comparison is full-width equality; X/Z are not treated specially.
- State machine:
  - IDLE -> RUN on start_i. Clears counters, err_o, pass_o, first_exp/first_act; the edge-k sample is the first capture.
  - RUN -> DRAIN on stop_i. The data_in_i present at the stop edge is not captured.
  - DRAIN -> DONE on the edge where the last valid entry is compared, i.e. the delay line becomes empty.
  - DONE -> IDLE unconditionally after one cycle.
- Boundary rules:
  - start_i outside IDLE is ignored. stop_i outside RUN is ignored.
  - start_i and stop_i together in IDLE: start wins, stop ignored.
  - Counters saturate at 2^CNT_W-1 and never wrap. err_o stays set.
  - Counters, first_* and pass_o hold their values in IDLE until the next start.

## Timing
- start at edge k, stop at edge m (m>k) gives m-k captures. Comparisons occur at edges k+LATENCY .. m-1+LATENCY.
- DRAIN->DONE at edge m-1+LATENCY. done_o and pass_o are valid in the following cycle.
- busy_o is high from edge k to edge m-1+LATENCY. It falls together with the rise of done_o.
- Alignment with LATENCY=1: data_out_i compared at edge e+1 is the register output written at edge e.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Good run: LATENCY=1 ideal register, stimulus 1..10 over 10 edges, then stop -> chk_cnt_o=10, err_cnt_o=0, pass_o=1, err_o=0, single done_o pulse one cycle after the last compare.
- Error injection: as the good run, but data_out_i forced to 0xDEAD_BEEF on the compare of value 4 -> err_cnt_o=1, err_o=1, first_exp_o=4, first_act_o=0xDEADBEEF, pass_o=0.
- Short run: LATENCY=3, start at edge k, stop at k+1 -> one compare at k+3, chk_cnt_o=1, done_o in the cycle after k+3.
- Ignored controls:
  - stop_i in IDLE -> no state change.
  - start_i during RUN -> counters not cleared.
  - start_i with stop_i in IDLE -> run starts.
- Reset mid-run: rst_i low for one cycle during DRAIN -> all outputs 0 immediately, IDLE, no done_o pulse afterwards.
- Saturation: CNT_W=4, 20 mismatching samples -> err_cnt_o=15, chk_cnt_o=15, err_o=1, pass_o=0.

Source files
------------

// File: rtl/reg_checker.sv
// Self-checking reader for a register test path: delays the stimulus by LATENCY
// cycles, compares it with the register output and reports counts and the first mismatch.
module reg_checker #(
   parameter int DWIDTH  = 32,
   parameter int LATENCY = 1,
   parameter int CNT_W   = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              stop_i,
   input  logic [DWIDTH-1:0] data_in_i,
   input  logic [DWIDTH-1:0] data_out_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              pass_o,
   output logic              err_o,
   output logic [CNT_W-1:0]  chk_cnt_o,
   output logic [CNT_W-1:0]  err_cnt_o,
   output logic [DWIDTH-1:0] first_exp_o,
   output logic [DWIDTH-1:0] first_act_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (&v) begin
         r = v;
      end else begin
         r = v + CNT_ONE;
      end
      return r;
   endfunction

   state_t              state_r;
   logic                busy_r;
   logic                done_r;
   logic                pass_r;
   logic                err_r;
   logic [CNT_W-1:0]    chk_cnt_r;
   logic [CNT_W-1:0]    err_cnt_r;
   logic [DWIDTH-1:0]   first_exp_r;
   logic [DWIDTH-1:0]   first_act_r;

   logic [DWIDTH-1:0]   dly_data_r [LATENCY];
   logic [LATENCY-1:0]  dly_vld_r;

   logic                start_s;
   logic                capture_s;
   logic                upstream_vld_s;
   logic                cmp_s;
   logic                mis_s;
   logic [CNT_W-1:0]    chk_cnt_nxt_s;
   logic [CNT_W-1:0]    err_cnt_nxt_s;

   // Capture decision, compare result and next counter values
   always_comb begin
      start_s        = (state_r == ST_IDLE) && start_i;
      capture_s      = start_s || ((state_r == ST_RUN) && !stop_i);
      // Any valid entry before the last stage means the line is not about to empty
      upstream_vld_s = 1'b0;
      for (int i = 0; i < LATENCY - 1; i++) begin
         upstream_vld_s = upstream_vld_s | dly_vld_r[i];
      end
      cmp_s          = dly_vld_r[LATENCY-1];
      mis_s          = cmp_s && (data_out_i != dly_data_r[LATENCY-1]);
      chk_cnt_nxt_s  = cmp_s ? sat_inc(chk_cnt_r) : chk_cnt_r;
      err_cnt_nxt_s  = mis_s ? sat_inc(err_cnt_r) : err_cnt_r;
   end

   // Stimulus delay line matching the latency of the register under test
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         dly_vld_r <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            dly_data_r[i] <= '0;
         end
      end else begin
         dly_vld_r[0]  <= capture_s;
         dly_data_r[0] <= data_in_i;
         for (int i = 1; i < LATENCY; i++) begin
            dly_vld_r[i]  <= dly_vld_r[i-1];
            dly_data_r[i] <= dly_data_r[i-1];
         end
      end
   end

   // Run control state machine with result counters and registered status
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_r     <= ST_IDLE;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         pass_r      <= 1'b0;
         err_r       <= 1'b0;
         chk_cnt_r   <= '0;
         err_cnt_r   <= '0;
         first_exp_r <= '0;
         first_act_r <= '0;
      end else begin
         done_r <= 1'b0;
         if (start_s) begin
            chk_cnt_r   <= '0;
            err_cnt_r   <= '0;
            err_r       <= 1'b0;
            pass_r      <= 1'b0;
            first_exp_r <= '0;
            first_act_r <= '0;
         end else begin
            chk_cnt_r <= chk_cnt_nxt_s;
            err_cnt_r <= err_cnt_nxt_s;
            if (mis_s) begin
               err_r <= 1'b1;
            end
            // A zero error count before this edge marks the first mismatch of the run
            if (mis_s && (err_cnt_r == '0)) begin
               first_exp_r <= dly_data_r[LATENCY-1];
               first_act_r <= data_out_i;
            end
         end

         case (state_r)
            ST_IDLE: begin
               if (start_i) begin
                  state_r <= ST_RUN;
                  busy_r  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (stop_i) begin
                  if (upstream_vld_s) begin
                     state_r <= ST_DRAIN;
                  end else begin
                     state_r <= ST_DONE;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                     pass_r  <= (err_cnt_nxt_s == '0) && (chk_cnt_nxt_s != '0);
                  end
               end
            end
            ST_DRAIN: begin
               if (!upstream_vld_s) begin
                  state_r <= ST_DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  pass_r  <= (err_cnt_nxt_s == '0) && (chk_cnt_nxt_s != '0);
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o      = busy_r;
   assign done_o      = done_r;
   assign pass_o      = pass_r;
   assign err_o       = err_r;
   assign chk_cnt_o   = chk_cnt_r;
   assign err_cnt_o   = err_cnt_r;
   assign first_exp_o = first_exp_r;
   assign first_act_o = first_act_r;

endmodule

// File: tb/tb_reg_checker.sv
// Scoreboard bench for reg_checker: two instances (LATENCY=1/CNT_W=16 and
// LATENCY=3/CNT_W=4) driven with randomized runs against a run-level reference model.
module tb_reg_checker;

   localparam int L0 = 1;
   localparam int L1 = 3;

   typedef struct {
      int          inst;
      int          done_cyc;
      logic [15:0] chk;
      logic [15:0] errc;
      logic        pass;
      logic        err;
      logic [31:0] fexp;
      logic [31:0] fact;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t exp_q[$];
   exp_t last0;
   exp_t last1;

   logic        start0 = 1'b0, stop0 = 1'b0, start1 = 1'b0, stop1 = 1'b0;
   logic [31:0] din0 = 32'd0, dout0 = 32'd0, din1 = 32'd0, dout1 = 32'd0;
   logic        busy0, done0, pass0, err0, busy1, done1, pass1, err1;
   logic [15:0] chk0, errc0;
   logic [3:0]  chk1, errc1;
   logic [31:0] fexp0, fact0, fexp1, fact1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   reg_checker #(.DWIDTH(32), .LATENCY(L0), .CNT_W(16)) u_l1 (
      .clk_i(clk), .rst_i(rst_n), .start_i(start0), .stop_i(stop0),
      .data_in_i(din0), .data_out_i(dout0), .busy_o(busy0), .done_o(done0),
      .pass_o(pass0), .err_o(err0), .chk_cnt_o(chk0), .err_cnt_o(errc0),
      .first_exp_o(fexp0), .first_act_o(fact0));

   reg_checker #(.DWIDTH(32), .LATENCY(L1), .CNT_W(4)) u_l3 (
      .clk_i(clk), .rst_i(rst_n), .start_i(start1), .stop_i(stop1),
      .data_in_i(din1), .data_out_i(dout1), .busy_o(busy1), .done_o(done1),
      .pass_o(pass1), .err_o(err1), .chk_cnt_o(chk1), .err_cnt_o(errc1),
      .first_exp_o(fexp1), .first_act_o(fact1));

   function automatic logic busy_of(input int i);
      return (i == 0) ? busy0 : busy1;
   endfunction
   function automatic logic done_of(input int i);
      return (i == 0) ? done0 : done1;
   endfunction
   function automatic logic pass_of(input int i);
      return (i == 0) ? pass0 : pass1;
   endfunction
   function automatic logic err_of(input int i);
      return (i == 0) ? err0 : err1;
   endfunction
   function automatic logic [15:0] chk_of(input int i);
      return (i == 0) ? chk0 : {12'd0, chk1};
   endfunction
   function automatic logic [15:0] errc_of(input int i);
      return (i == 0) ? errc0 : {12'd0, errc1};
   endfunction
   function automatic logic [31:0] fexp_of(input int i);
      return (i == 0) ? fexp0 : fexp1;
   endfunction
   function automatic logic [31:0] fact_of(input int i);
      return (i == 0) ? fact0 : fact1;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_zero(input int i, input string tag);
      check($sformatf("%s_i%0d_busy", tag, i), 64'(busy_of(i)), 64'd0);
      check($sformatf("%s_i%0d_done", tag, i), 64'(done_of(i)), 64'd0);
      check($sformatf("%s_i%0d_pass", tag, i), 64'(pass_of(i)), 64'd0);
      check($sformatf("%s_i%0d_err", tag, i), 64'(err_of(i)), 64'd0);
      check($sformatf("%s_i%0d_chk_cnt", tag, i), 64'(chk_of(i)), 64'd0);
      check($sformatf("%s_i%0d_err_cnt", tag, i), 64'(errc_of(i)), 64'd0);
      check($sformatf("%s_i%0d_first_exp", tag, i), 64'(fexp_of(i)), 64'd0);
      check($sformatf("%s_i%0d_first_act", tag, i), 64'(fact_of(i)), 64'd0);
   endtask

   task automatic set_in(input int inst, input logic st, input logic sp,
                         input logic [31:0] dv, input logic [31:0] ov);
      if (inst == 0) begin
         start0 = st; stop0 = sp; din0 = dv; dout0 = ov;
      end else begin
         start1 = st; stop1 = sp; din1 = dv; dout1 = ov;
      end
   endtask

   // Monitor: pops the expected run result whenever an instance pulses done_o
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 2; i++) begin
            if (done_of(i)) begin
               if (exp_q.size() == 0 || exp_q[0].inst != i) begin
                  check($sformatf("i%0d_unexpected_done", i), 64'(done_of(i)), 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  check($sformatf("i%0d_done_cycle", i), 64'(cyc), 64'(e.done_cyc));
                  check($sformatf("i%0d_busy_at_done", i), 64'(busy_of(i)), 64'd0);
                  check($sformatf("i%0d_chk_cnt", i), 64'(chk_of(i)), 64'(e.chk));
                  check($sformatf("i%0d_err_cnt", i), 64'(errc_of(i)), 64'(e.errc));
                  check($sformatf("i%0d_pass", i), 64'(pass_of(i)), 64'(e.pass));
                  check($sformatf("i%0d_err", i), 64'(err_of(i)), 64'(e.err));
                  check($sformatf("i%0d_first_exp", i), 64'(fexp_of(i)), 64'(e.fexp));
                  check($sformatf("i%0d_first_act", i), 64'(fact_of(i)), 64'(e.fact));
               end
            end
         end
      end
   end

   // One checking run: n captured samples; mode 0 = 1..n clean, 1 = 1..n with
   // 0xDEADBEEF on value 4, 2 = random with random corruption, 3 = all corrupted.
   task automatic run(input int inst, input int n, input int mode, input bit ss,
                      input bit mid, input bit abort);
      logic [31:0] samp[$];
      logic [31:0] cval[$];
      bit          corr[$];
      logic [31:0] s, cv, dv, ov;
      bit          cr, st, sp;
      int          lat, maxc, k, nerr, first, j;
      exp_t        e;
      lat   = (inst == 0) ? L0 : L1;
      maxc  = (inst == 0) ? 65535 : 15;
      nerr  = 0;
      first = -1;
      k     = 0;
      for (int q = 0; q < n; q++) begin
         cv = 32'd0;
         case (mode)
            0: begin s = 32'(q + 1); cr = 1'b0; end
            1: begin s = 32'(q + 1); cr = (q == 3); cv = 32'hDEAD_BEEF; end
            2: begin
               s  = $urandom;
               cr = ($urandom_range(3, 0) == 0);
               cv = $urandom;
               if (cv == s) cv = ~s;
            end
            default: begin s = $urandom; cr = 1'b1; cv = s ^ ($urandom | 32'd1); end
         endcase
         if (cr) begin
            nerr++;
            if (first < 0) first = q;
         end
         samp.push_back(s);
         corr.push_back(cr);
         cval.push_back(cv);
      end
      for (int c = 0; c <= n + lat + 1; c++) begin
         @(negedge clk);
         if (c == 0) begin
            k          = cyc + 1;
            e.inst     = inst;
            e.done_cyc = k + n - 1 + lat;
            e.chk      = 16'((n < maxc) ? n : maxc);
            e.errc     = 16'((nerr < maxc) ? nerr : maxc);
            e.err      = (nerr > 0);
            e.pass     = (nerr == 0) && (n > 0);
            e.fexp     = (first >= 0) ? samp[first] : 32'd0;
            e.fact     = (first >= 0) ? cval[first] : 32'd0;
            if (!abort) begin
               exp_q.push_back(e);
               if (inst == 0) last0 = e; else last1 = e;
            end
         end
         if (abort && c == n + 1) begin
            rst_n = 1'b0;
            #1;
            check_zero(inst, "abort_reset");
         end
         if (abort && c == n + 2) rst_n = 1'b1;
         if (!abort && c == 1) check($sformatf("i%0d_busy_first", inst), 64'(busy_of(inst)), 64'd1);
         if (!abort && c == n + lat - 1) check($sformatf("i%0d_busy_last", inst), 64'(busy_of(inst)), 64'd1);
         if (!abort && c == n + lat) check($sformatf("i%0d_busy_fell", inst), 64'(busy_of(inst)), 64'd0);
         st = (c == 0) || (mid && n >= 2 && c == n / 2);
         sp = (c == n) || (ss && c == 0);
         dv = (c < n) ? samp[c] : $urandom;
         j  = c - lat;
         if (j >= 0 && j < n) ov = corr[j] ? cval[j] : samp[j];
         else ov = $urandom;
         set_in(inst, st, sp, dv, ov);
      end
      if (!abort) check($sformatf("i%0d_done_missing", inst), 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   // stop_i while idle must not start anything and results must hold
   task automatic idle_stop(input int inst);
      exp_t e;
      e = (inst == 0) ? last0 : last1;
      @(negedge clk);
      set_in(inst, 1'b0, 1'b1, $urandom, $urandom);
      @(negedge clk);
      set_in(inst, 1'b0, 1'b0, $urandom, $urandom);
      repeat (3) @(negedge clk);
      check($sformatf("i%0d_idle_stop_busy", inst), 64'(busy_of(inst)), 64'd0);
      check($sformatf("i%0d_hold_chk_cnt", inst), 64'(chk_of(inst)), 64'(e.chk));
      check($sformatf("i%0d_hold_err_cnt", inst), 64'(errc_of(inst)), 64'(e.errc));
      check($sformatf("i%0d_hold_pass", inst), 64'(pass_of(inst)), 64'(e.pass));
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_zero(0, "reset");
      check_zero(1, "reset");
      rst_n = 1'b1;
      @(negedge clk);

      run(0, 10, 0, 1'b0, 1'b0, 1'b0);
      idle_stop(0);
      run(0, 10, 1, 1'b0, 1'b0, 1'b0);
      run(0, 12, 2, 1'b0, 1'b1, 1'b0);
      run(0, 5, 0, 1'b1, 1'b0, 1'b0);
      run(0, 1, 0, 1'b0, 1'b0, 1'b0);
      repeat (5) run(0, int'($urandom_range(20, 1)), 2, 1'($urandom_range(1, 0)),
                     1'($urandom_range(1, 0)), 1'b0);

      run(1, 1, 0, 1'b0, 1'b0, 1'b0);
      idle_stop(1);
      repeat (4) run(1, int'($urandom_range(20, 1)), 2, 1'($urandom_range(1, 0)),
                     1'($urandom_range(1, 0)), 1'b0);
      run(1, 20, 3, 1'b0, 1'b0, 1'b0);
      run(1, 6, 0, 1'b0, 1'b0, 1'b0);
      run(1, 4, 3, 1'b0, 1'b0, 1'b1);
      run(1, 4, 0, 1'b0, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
